// File: rtl/wb_pkg.sv
// Shared types for the write buffer: entry layout, depth/pointer sizing and pointer wrap.
package wb_pkg;

   localparam int WB_LOG_DEPTH  = 2;
   localparam int WB_ADDR_WIDTH = 8;
   localparam int WB_DATA_WIDTH = 32;

   localparam int DEPTH     = 2 ** WB_LOG_DEPTH;
   localparam int PTR_WIDTH = WB_LOG_DEPTH;

   typedef logic [PTR_WIDTH-1:0] ptr_t;
   typedef logic [PTR_WIDTH:0]   cnt_t;

   localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

   typedef struct packed {
      logic [WB_ADDR_WIDTH-1:0] addr;
      logic [WB_DATA_WIDTH-1:0] data;
   } wb_entry_t;

   // DEPTH is a power of two, so natural overflow of the pointer is the wrap.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return p + ptr_t'(1);
   endfunction

endpackage

// File: rtl/wb_lookup.sv
// Youngest-first address match over the buffer entries.
// Purely combinational; no state, no backpressure.
module wb_lookup
   import wb_pkg::*;
#(
   parameter int N  = DEPTH,
   parameter int PW = PTR_WIDTH
) (
   input  wb_entry_t                i_entries [N],
   input  logic [N-1:0]             i_valid,
   input  logic [PW-1:0]            i_wptr,
   input  logic [WB_ADDR_WIDTH-1:0] i_addr,
   output logic                     o_hit,
   output logic [WB_DATA_WIDTH-1:0] o_data
);

   logic [PW-1:0] w_idx;

   // Walk oldest slot to youngest so the last match written is the youngest one.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = '0;
      for (int i = N; i >= 1; i--) begin
         w_idx = i_wptr - PW'(i);
         if (i_valid[w_idx] && (i_entries[w_idx].addr == i_addr)) begin
            o_hit  = 1'b1;
            o_data = i_entries[w_idx].data;
         end
      end
   end

endmodule

// File: rtl/write_buffer.sv
// FIFO store buffer between write-through cache and memory, with newest-match lookup (option WB_COALESCE_EN).
// Latency: accepted store is presented to memory the cycle after acceptance; no bypass.
// Backpressure: wr_ready drops when full; head holds while mem_wr_ready is low.
module write_buffer
   import wb_pkg::*;
#(
   parameter int LOG_DEPTH  = WB_LOG_DEPTH,
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  mem_wr_valid,
   input  logic                  mem_wr_ready,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [ADDR_WIDTH-1:0] lk_addr,
   output logic                  lk_hit,
   output logic [DATA_WIDTH-1:0] lk_data,
   output logic [LOG_DEPTH:0]    count,
   output logic                  drained
);

   ptr_t       r_rptr;
   ptr_t       r_wptr;
   cnt_t       r_count;
   wb_entry_t  r_mem [DEPTH];

   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_merge_hit;
   logic [DEPTH-1:0] w_vmask;
   ptr_t             w_off;
   wb_entry_t        w_head;

   assign w_full = (r_count == FULL_CNT);

`ifdef WB_COALESCE_EN
   ptr_t w_young;
   assign w_young = r_wptr - ptr_t'(1);
   // With two or more entries the youngest is never the head being presented, so it is safe to rewrite.
   assign w_merge_hit = (r_count >= cnt_t'(2)) && (r_mem[w_young].addr == wr_addr);
`else
   assign w_merge_hit = 1'b0;
`endif

   assign wr_ready     = !w_full || w_merge_hit;
   assign w_push       = wr_valid && wr_ready && !w_merge_hit;
   assign mem_wr_valid = (r_count != '0);
   assign w_pop        = mem_wr_valid && mem_wr_ready;
   assign drained      = (r_count == '0);
   assign count        = r_count;

   assign w_head      = r_mem[r_rptr];
   assign mem_wr_addr = w_head.addr;
   assign mem_wr_data = w_head.data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
         if (w_push && !w_pop)
            r_count <= r_count + cnt_t'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - cnt_t'(1);
      end
   end

   // Entry storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= wb_entry_t'{addr: wr_addr, data: wr_data};
`ifdef WB_COALESCE_EN
      else if (wr_valid && w_merge_hit)
         r_mem[w_young].data <= wr_data;
`endif
   end

   always_comb begin
      w_vmask = '0;
      w_off   = '0;
      for (int j = 0; j < DEPTH; j++) begin
         w_off      = ptr_t'(j) - r_rptr;
         w_vmask[j] = ({1'b0, w_off} < r_count);
      end
   end

   wb_lookup #(
      .N  (DEPTH),
      .PW (PTR_WIDTH)
   ) u_lookup (
      .i_entries (r_mem),
      .i_valid   (w_vmask),
      .i_wptr    (r_wptr),
      .i_addr    (lk_addr),
      .o_hit     (lk_hit),
      .o_data    (lk_data)
   );

endmodule

// File: tb/tb_write_buffer.sv
// Directed + random bench for write_buffer with a queue scoreboard of pending stores.
module tb_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        mem_wr_valid;
   logic        mem_wr_ready;
   logic [7:0]  mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [7:0]  lk_addr;
   logic        lk_hit;
   logic [31:0] lk_data;
   logic [2:0]  count;
   logic        drained;

   int compared   = 0;
   int mismatched = 0;
   logic [39:0] q[$];

   always #5 clk = ~clk;

   write_buffer dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_ready (mem_wr_ready),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .lk_addr      (lk_addr),
      .lk_hit       (lk_hit),
      .lk_data      (lk_data),
      .count        (count),
      .drained      (drained)
   );

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] model_lk(input logic [7:0] a);
      logic [32:0] r;
      r = '0;
      for (int k = 0; k < q.size(); k++)
         if (q[k][39:32] == a) r = {1'b1, q[k][31:0]};
      return r;
   endfunction

   // Called at posedge+1: drive, check pre-edge outputs against the model, update model, advance a cycle.
   task automatic cyc(input logic v, input logic [7:0] a, input logic [31:0] d, input logic rdy);
      logic        exp_rdy;
      logic        merge;
      logic        push;
      logic        pop;
      logic [32:0] lk;
      logic [39:0] tmp;
      int          n;
      wr_valid     = v;
      wr_addr      = a;
      wr_data      = d;
      mem_wr_ready = rdy;
      #1;
      n     = q.size();
      merge = 1'b0;
`ifdef WB_COALESCE_EN
      if (n >= 2 && q[n-1][39:32] == a) merge = 1'b1;
`endif
      exp_rdy = (n != 4) || merge;
      check("wr_ready", 40'(wr_ready), 40'(exp_rdy));
      check("mem_wr_valid", 40'(mem_wr_valid), 40'(n != 0));
      check("count", 40'(count), 40'(n));
      check("drained", 40'(drained), 40'(n == 0));
      if (n != 0) begin
         check("head_addr", 40'(mem_wr_addr), 40'(q[0][39:32]));
         check("head_data", 40'(mem_wr_data), 40'(q[0][31:0]));
      end
      lk = model_lk(lk_addr);
      check("lk_hit", 40'(lk_hit), 40'(lk[32]));
      check("lk_data", 40'(lk_data), 40'(lk[31:0]));
      push = v && exp_rdy && !merge;
      pop  = rdy && (n != 0);
      if (v && merge) begin
         tmp        = q[n-1];
         tmp[31:0]  = d;
         q[n-1]     = tmp;
      end
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({a, d});
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && q.size() != 0; i++)
         cyc(1'b0, 8'h00, 32'h0, 1'b1);
      check("drain_done", 40'(drained), 40'(1));
   endtask

   initial begin
      rst          = 1'b0;
      wr_valid     = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      mem_wr_ready = 1'b0;
      lk_addr      = '0;
      #2 rst = 1'b1;
      #2;
      check("rst_wr_ready", 40'(wr_ready), 40'(1));
      check("rst_mem_vld", 40'(mem_wr_valid), 40'(0));
      check("rst_count", 40'(count), 40'(0));
      check("rst_drained", 40'(drained), 40'(1));
      check("rst_lk_hit", 40'(lk_hit), 40'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(1'b0, 8'h00, 32'h0, 1'b0);
      cyc(1'b0, 8'h00, 32'h0, 1'b0);

      // In-order drain and one-cycle latency into an empty buffer.
      cyc(1'b1, 8'h10, 32'hA, 1'b0);
      cyc(1'b1, 8'h14, 32'hB, 1'b0);
      cyc(1'b1, 8'h18, 32'hC, 1'b0);
      drain();

      // Asynchronous reset mid-drain with three entries held.
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h50 + 8'(i), 32'h500 + 32'(i), 1'b0);
      cyc(1'b0, 8'h00, 32'h0, 1'b1);
      wr_valid     = 1'b0;
      mem_wr_ready = 1'b1;
      #1;
      check("pre_rst_count", 40'(count), 40'(3));
      #1 rst = 1'b1;
      #1;
      check("mid_rst_count", 40'(count), 40'(0));
      check("mid_rst_mem_vld", 40'(mem_wr_valid), 40'(0));
      check("mid_rst_wr_ready", 40'(wr_ready), 40'(1));
      check("mid_rst_drained", 40'(drained), 40'(1));
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(1'b0, 8'h00, 32'h0, 1'b0);

      // Full: simultaneous push+pop refuses the push, retry succeeds.
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h60 + 8'(i), 32'h600 + 32'(i), 1'b0);
      cyc(1'b1, 8'h70, 32'h5, 1'b1);
      cyc(1'b1, 8'h70, 32'h5, 1'b0);
      check("full_retry_count", 40'(count), 40'(4));
      cyc(1'b0, 8'h00, 32'h0, 1'b0);
      drain();

      // Lookup returns the youngest match; a store being pushed does not hit yet.
      cyc(1'b1, 8'h20, 32'h1, 1'b0);
      cyc(1'b1, 8'h24, 32'h2, 1'b0);
      lk_addr = 8'h20;
      cyc(1'b1, 8'h20, 32'h3, 1'b0);
      #1;
      check("lk20_hit", 40'(lk_hit), 40'(1));
      check("lk20_data", 40'(lk_data), 40'(3));
      lk_addr = 8'h28;
      #1;
      check("lk28_hit", 40'(lk_hit), 40'(0));
      check("lk28_data", 40'(lk_data), 40'(0));
      lk_addr = 8'h20;
      drain();

      // Random traffic with stalls; pointers wrap many times.
      for (int i = 0; i < 60; i++) begin
         lk_addr = 8'h80 + 8'($urandom_range(0, 4) * 4);
         cyc(($urandom_range(0, 3) != 0), 8'h80 + 8'($urandom_range(0, 3) * 4),
             32'h1000 + 32'(i), 1'($urandom_range(0, 1)));
      end
      drain();

`ifdef WB_COALESCE_EN
      cyc(1'b1, 8'h30, 32'h1, 1'b0);
      cyc(1'b1, 8'h34, 32'h2, 1'b0);
      cyc(1'b1, 8'h34, 32'h9, 1'b0);
      check("coal_count", 40'(count), 40'(2));
      cyc(1'b0, 8'h00, 32'h0, 1'b1);
      check("coal_second_data", 40'(mem_wr_data), 40'(32'h9));
      drain();
      cyc(1'b1, 8'h40, 32'h5, 1'b0);
      cyc(1'b1, 8'h40, 32'h6, 1'b0);
      check("no_merge_head_count", 40'(count), 40'(2));
      drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
